sdram_soc_bridge: RTL and testbench
===================================

Name: sdram_soc_bridge

Overview:
- Upstream request stage for sdram_controller: accepts SoC read/write requests on a valid/ready interface and queues them in a small command FIFO.
- Issues each request, one at a time, on the controller's soc_side busy/ready interface.
- Returns read data on a held response channel.
- Decouples SoC timing from controller init (~400 us) and refresh stalls.

Parameters:
ADDR_WIDTH, 23, word address width (8M x 32-bit words)
DATA_WIDTH, 32, data width
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2
TIMEOUT_CYCLES, 1024, watchdog limit per command (used only with optional feature)

Ports:
clk  in  1  system clock (80 MHz)
reset_port  in  1  asynchronous reset, active-high
host_req_valid_port  in  1  request valid
host_req_ready_port  out  1  request accepted when valid & ready
host_req_we_port  in  1  1 = write, 0 = read
host_req_addr_port  in  ADDR_WIDTH  word address
host_req_wdata_port  in  DATA_WIDTH  write data
host_req_mask_port  in  4  byte enables (1 = write byte)
host_rsp_valid_port  out  1  read data valid, held until taken
host_rsp_ready_port  in  1  response consumed when valid & ready
host_rsp_data_port  out  DATA_WIDTH  read data
fifo_level_port  out  $clog2(FIFO_DEPTH)+1  entries queued
err_port  out  1  sticky timeout flag
ctrl_busy_port  in  1  from controller soc_side_busy
ctrl_ready_port  in  1  from controller soc_side_ready; 1-cycle pulse, read data valid
ctrl_rd_data_port  in  DATA_WIDTH  from controller soc_side_rd_data
ctrl_addr_port  out  ADDR_WIDTH  to soc_side_addr
ctrl_wr_data_port  out  DATA_WIDTH  to soc_side_wr_data
ctrl_wr_mask_port  out  4  to soc_side_wr_mask
ctrl_wr_en_port  out  1  to soc_side_wr_en
ctrl_rd_en_port  out  1  to soc_side_rd_en

Behaviour:
Reset:
- All registered outputs are 0; FIFO is flushed; state is IDLE.
- host_req_ready_port = 1 as soon as reset deasserts.
- Reset mid-operation drops the in-flight command and any pending response, with no completion reported.

FIFO:
- host_req_ready_port = !full (combinational).
- Push occurs on valid & ready; pop occurs on IDLE->ISSUE.
- A push while full is refused, even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE:
  - If FIFO is non-empty, ctrl_busy_port = 0, and (head is a write or host_rsp_valid_port = 0): pop head into the command register, go to ISSUE.
  - If FIFO is empty: stay in IDLE.
- ISSUE:
  - ctrl_addr/wr_data/wr_mask are driven from the command register; ctrl_wr_en_port or ctrl_rd_en_port = 1 per the we bit.
  - On the first cycle ctrl_busy_port = 1: deassert the strobe in that cycle and go to WAIT_DONE.
  - Address, data and mask stay stable from ISSUE through WAIT_DONE.
- WAIT_DONE:
  - Write: complete on the first cycle ctrl_busy_port = 0, then go to IDLE.
  - Read: complete on ctrl_ready_port = 1. Capture ctrl_rd_data_port into the response register and set host_rsp_valid_port next cycle. Go to IDLE.
  - A read whose ctrl_ready pulse arrives while busy is still 1 is complete; IDLE then waits for busy = 0 before the next issue.

Timing and ordering:
- Latency: request pushed into an empty FIFO at cycle N with the controller idle -> strobe high at N+2.
- Exactly one command is in flight; commands complete in FIFO order.
- A read at the FIFO head stalls while an untaken response is pending.
- Response: host_rsp_valid_port clears on valid & ready. A new response is never loaded while valid = 1.

Optional Feature:
Macro SDRAM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to ISSUE and increments each cycle in ISSUE/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: drop the strobe, set err_port (sticky until reset), go to IDLE.
  - A timed-out read returns a response with data 32'hDEADBEEF.
- Not defined: no counter; err_port tied 0; the FSM waits indefinitely.

Test Plan:
- Init stall: ctrl_busy_port = 1 for 32000 cycles after reset; push 4 writes -> host_req_ready_port = 0 after the 4th, fifo_level_port = 4, no strobe until busy falls.
- Single write: addr 23'd8086, data 32'hCCF0F0F1, mask 4'b1111 -> ctrl outputs match; ctrl_wr_en_port high from 2 cycles after push until the busy rise, then 0; completes when busy falls.
- Read: model returns 32'h12345678 with a ctrl_ready pulse 6 cycles after busy -> host_rsp_valid_port = 1 with data 32'h12345678, held until host_rsp_ready_port = 1.
- Ordering/backpressure: push R(addr 1), W(addr 2), R(addr 3) with host_rsp_ready_port = 0 -> W issues; R(3) is not issued until the first response is taken; issue order is 1, 2, 3.
- Reset mid-read: assert reset_port in WAIT_DONE -> all outputs 0 and fifo_level_port = 0 next cycle; no response produced.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): busy never rises on a read -> strobe drops at cycle 16, err_port = 1, response data 32'hDEADBEEF.

Source files
------------

// File: rtl/sdram_soc_bridge.sv
// SoC-side request bridge for sdram_controller: queues requests and issues them one at a time.
// Optional per-command watchdog enabled by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_soc_bridge #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_port,
  input  logic                          host_req_valid_port,
  output logic                          host_req_ready_port,
  input  logic                          host_req_we_port,
  input  logic [ADDR_WIDTH-1:0]         host_req_addr_port,
  input  logic [DATA_WIDTH-1:0]         host_req_wdata_port,
  input  logic [3:0]                    host_req_mask_port,
  output logic                          host_rsp_valid_port,
  input  logic                          host_rsp_ready_port,
  output logic [DATA_WIDTH-1:0]         host_rsp_data_port,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_port,
  output logic                          err_port,
  input  logic                          ctrl_busy_port,
  input  logic                          ctrl_ready_port,
  input  logic [DATA_WIDTH-1:0]         ctrl_rd_data_port,
  output logic [ADDR_WIDTH-1:0]         ctrl_addr_port,
  output logic [DATA_WIDTH-1:0]         ctrl_wr_data_port,
  output logic [3:0]                    ctrl_wr_mask_port,
  output logic                          ctrl_wr_en_port,
  output logic                          ctrl_rd_en_port
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Legal configurations never elaborate this block.
  if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            mask;
  } cmd_t;

  cmd_t                  mem_q [FIFO_DEPTH];
  cmd_t                  head;
  cmd_t                  cmd_q, cmd_d;
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  full, empty, push, pop;
  logic                  wr_en, rd_en;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = host_req_valid_port && !full;
  assign head  = mem_q[rd_ptr_q];

  // Queue storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{we:   host_req_we_port,
                           addr: host_req_addr_port,
                           data: host_req_wdata_port,
                           mask: host_req_mask_port};
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    if (rsp_valid_q && host_rsp_ready_port) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A read may not start while the previous response is still untaken.
        if (!empty && !ctrl_busy_port && (head.we || !rsp_valid_q)) begin
          pop     = 1'b1;
          cmd_d   = head;
          state_d = ISSUE;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (ctrl_busy_port) begin
          state_d = WAIT_DONE;
        end else begin
          wr_en = cmd_q.we;
          rd_en = !cmd_q.we;
        end
      end
      WAIT_DONE: begin
        if (cmd_q.we) begin
          if (!ctrl_busy_port) state_d = IDLE;
        end else if (ctrl_ready_port) begin
          rsp_data_d  = ctrl_rd_data_port;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES) && state_d != IDLE) begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
        if (!cmd_q.we) begin
          rsp_data_d  = 32'hDEADBEEF;
          rsp_valid_d = 1'b1;
        end
      end
    end
`endif

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_port = err_q;
`else
  assign err_port = 1'b0;
`endif

  assign host_req_ready_port = !full;
  assign host_rsp_valid_port = rsp_valid_q;
  assign host_rsp_data_port  = rsp_data_q;
  assign fifo_level_port     = level_q;
  assign ctrl_addr_port      = cmd_q.addr;
  assign ctrl_wr_data_port   = cmd_q.data;
  assign ctrl_wr_mask_port   = cmd_q.mask;
  assign ctrl_wr_en_port     = wr_en;
  assign ctrl_rd_en_port     = rd_en;

endmodule

// File: tb/tb_sdram_soc_bridge.sv
// Directed bench for sdram_soc_bridge; the controller side is driven by hand step by step.
module tb_sdram_soc_bridge;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_mask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [2:0]    level;
  logic          err;
  logic          busy, ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [3:0]    c_mask;
  logic          wr_en, rd_en;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_soc_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .reset_port          (rst),
    .host_req_valid_port (req_valid),
    .host_req_ready_port (req_ready),
    .host_req_we_port    (req_we),
    .host_req_addr_port  (req_addr),
    .host_req_wdata_port (req_wdata),
    .host_req_mask_port  (req_mask),
    .host_rsp_valid_port (rsp_valid),
    .host_rsp_ready_port (rsp_ready),
    .host_rsp_data_port  (rsp_data),
    .fifo_level_port     (level),
    .err_port            (err),
    .ctrl_busy_port      (busy),
    .ctrl_ready_port     (ready),
    .ctrl_rd_data_port   (rd_data),
    .ctrl_addr_port      (c_addr),
    .ctrl_wr_data_port   (c_wdata),
    .ctrl_wr_mask_port   (c_mask),
    .ctrl_wr_en_port     (wr_en),
    .ctrl_rd_en_port     (rd_en)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_mask = 4'hF;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    k = 0;
    while (!(wr_en || rd_en) && k < 40) begin
      cyc();
      k++;
    end
    chk({tag, "_strobe_seen"}, 64'(wr_en || rd_en), 64'd1);
  endtask

  task automatic serve_write(input logic [AW-1:0] a);
    wait_strobe("wr");
    chk("wr_en_high", 64'(wr_en), 64'd1);
    chk("wr_addr", 64'(c_addr), 64'(a));
    busy = 1'b1;
    #1 chk("wr_en_drop", 64'(wr_en), 64'd0);
    cyc();
    busy = 1'b0;
    cyc();
  endtask

  task automatic serve_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic early);
    wait_strobe("rd");
    chk("rd_en_high", 64'(rd_en), 64'd1);
    chk("rd_addr", 64'(c_addr), 64'(a));
    busy = 1'b1;
    #1 chk("rd_en_drop", 64'(rd_en), 64'd0);
    cyc();
    cyc();
    rd_data = d; ready = 1'b1;
    if (!early) busy = 1'b0;
    cyc();
    ready = 1'b0; rd_data = '0;
    chk("rsp_valid_set", 64'(rsp_valid), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(d));
    if (early) begin
      cyc();
      chk("idle_waits_busy", 64'(wr_en || rd_en), 64'd0);
      busy = 1'b0;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_mask = '0; rsp_ready = 1'b0; busy = 1'b0; ready = 1'b0; rd_data = '0;
    cyc();
    cyc();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_strobes", 64'(wr_en || rd_en), 64'd0);
    chk("rst_addr", 64'(c_addr), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Controller initialising: queue fills, nothing issues.
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, AW'(100 + i), DW'(i));
    chk("stall_level", 64'(level), 64'd4);
    chk("stall_ready", 64'(req_ready), 64'd0);
    push(1'b1, AW'(999), DW'(999));
    chk("full_push_refused", 64'(level), 64'd4);
    repeat (32000) cyc();
    chk("stall_no_strobe", 64'(wr_en || rd_en), 64'd0);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) serve_write(AW'(100 + i));
    chk("drain_level", 64'(level), 64'd0);

    // Single write with latency check.
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(8086); req_wdata = 32'hCCF0F0F1;
    req_mask = 4'b1111;
    cyc();
    req_valid = 1'b0;
    chk("w_level_after_push", 64'(level), 64'd1);
    chk("w_no_strobe_n1", 64'(wr_en), 64'd0);
    cyc();
    chk("w_strobe_n2", 64'(wr_en), 64'd1);
    chk("w_no_rd", 64'(rd_en), 64'd0);
    chk("w_addr", 64'(c_addr), 64'd8086);
    chk("w_data", 64'(c_wdata), 64'hCCF0F0F1);
    chk("w_mask", 64'(c_mask), 64'hF);
    busy = 1'b1;
    #1 chk("w_strobe_drop", 64'(wr_en), 64'd0);
    cyc();
    cyc();
    chk("w_addr_stable", 64'(c_addr), 64'd8086);
    chk("w_data_stable", 64'(c_wdata), 64'hCCF0F0F1);
    busy = 1'b0;
    cyc();
    cyc();
    chk("w_done_idle", 64'(wr_en || rd_en), 64'd0);

    // Read with held response.
    push(1'b0, AW'(55), '0);
    cyc();
    chk("r_strobe", 64'(rd_en), 64'd1);
    chk("r_no_wr", 64'(wr_en), 64'd0);
    chk("r_addr", 64'(c_addr), 64'd55);
    busy = 1'b1;
    #1 chk("r_strobe_drop", 64'(rd_en), 64'd0);
    repeat (5) cyc();
    rd_data = 32'h12345678; ready = 1'b1; busy = 1'b0;
    cyc();
    ready = 1'b0; rd_data = '0;
    chk("r_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("r_rsp_data", 64'(rsp_data), 64'h12345678);
    repeat (3) cyc();
    chk("r_rsp_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("r_rsp_taken", 64'(rsp_valid), 64'd0);

    // Ordering and response backpressure: R1, W2, R3.
    busy = 1'b1;
    push(1'b0, AW'(1), '0);
    push(1'b1, AW'(2), DW'(2));
    push(1'b0, AW'(3), '0);
    chk("ord_level", 64'(level), 64'd3);
    busy = 1'b0;
    serve_read(AW'(1), 32'hAAAA0001, 1'b1);
    serve_write(AW'(2));
    repeat (5) cyc();
    chk("ord_r3_stalled", 64'(rd_en), 64'd0);
    chk("ord_r3_queued", 64'(level), 64'd1);
    chk("ord_rsp1_held", 64'(rsp_data), 64'hAAAA0001);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("ord_rsp1_taken", 64'(rsp_valid), 64'd0);
    serve_read(AW'(3), 32'hBBBB0003, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset while a read is outstanding.
    push(1'b0, AW'(77), '0);
    cyc();
    busy = 1'b1;
    cyc();
    chk("mr_addr_before", 64'(c_addr), 64'd77);
    rst = 1'b1;
    #1;
    chk("mr_addr_cleared", 64'(c_addr), 64'd0);
    chk("mr_level_cleared", 64'(level), 64'd0);
    cyc();
    chk("mr_strobes", 64'(wr_en || rd_en), 64'd0);
    ready = 1'b1; rd_data = 32'h5;
    cyc();
    ready = 1'b0; rd_data = '0; busy = 1'b0; rst = 1'b0;
    repeat (3) cyc();
    chk("mr_no_response", 64'(rsp_valid), 64'd0);
    chk("mr_no_strobe", 64'(wr_en || rd_en), 64'd0);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    push(1'b0, AW'(64), '0);
    cyc();
    chk("to_strobe_first", 64'(rd_en), 64'd1);
    repeat (15) cyc();
    chk("to_strobe_cycle15", 64'(rd_en), 64'd1);
    cyc();
    chk("to_strobe_drop", 64'(rd_en), 64'd0);
    cyc();
    chk("to_err", 64'(err), 64'd1);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
`else
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
